irq_gateway: RTL and testbench
==============================

# irq_gateway

Interrupt gateway that consumes the timer's `interrupt` output plus up to N_SRC-1 other peripheral interrupt lines. Each source is captured as level or rising-edge, latched in a pending register, masked by an enable register, and combined into one registered `irq` line to the core. Software configures, inspects and acknowledges sources through a 32-bit AXI4-lite slave on the L3 peripheral bus. Source 0 is wired to the timer.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources (1..32); source 0 is the timer.
- ADDR_LEN, 5, decoded low address bits of AWADDR/ARADDR.

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  reset, synchronous, active-low.
- src  in  N_SRC  interrupt inputs, synchronous to clk, active-high.
- irq  out  1  combined interrupt to the core, registered.
- S_AXI_AWADDR  in  `C_AXI_L3_ADDR_WIDTH`  write address; only [ADDR_LEN-1:0] decoded.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  `C_AXI_L3_DATA_WIDTH` (=32)  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID/S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always OKAY (2'b00).
- S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response.
- S_AXI_ARADDR  in  `C_AXI_L3_ADDR_WIDTH`  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID/S_AXI_RREADY  out/in  1  read response.

## Operation
- Register map (byte offsets): 0x00 PENDING (RO); 0x04 ENABLE (RW); 0x08 MODE (RW, 1 = rising edge, 0 = level); 0x0C CLEAR (WO, write-1-to-clear pending, reads 0); 0x10 CLAIM (RO, lowest index i with pending[i]&enable[i], returned as i+1; 0 if none). Other offsets: writes ignored, reads 0, response OKAY.
- Bits at or above N_SRC read 0 and are not writable.
- ENABLE, MODE, CLEAR honour WSTRB per byte lane.
- src_q registers src every cycle. Level mode: pending[i] <= src[i]; CLEAR has no effect. Edge mode: pending[i] set when src[i] & ~src_q[i], cleared by CLEAR bit; a simultaneous set and clear leaves the bit set.
- A MODE write clears pending for every bit whose mode changes.
- irq <= |(pending & enable), registered.
- Write FSM: IDLE -> RESP. In IDLE, when AWVALID & WVALID are both high, AWREADY and WREADY pulse together for one cycle, the register updates, and the FSM moves to RESP. RESP holds BVALID until BREADY, then returns to IDLE. No write is accepted while BVALID is high.
- Read FSM: IDLE -> DATA. In IDLE, ARVALID pulses ARREADY for one cycle and RDATA is captured. DATA holds RVALID and a stable RDATA until RREADY.
- Read and write channels are independent. If a read samples a register in the same cycle that a write updates it, the read returns the old value.

## Timing
- Reset values: all registers 0; irq, AWREADY, WREADY, BVALID, ARREADY, RVALID = 0; RDATA = 0; BRESP/RRESP = 0.
- Source edge at cycle t -> pending at t+1 -> irq at t+2 (if enabled).
- CLEAR accepted at cycle t -> pending clear at t+1 -> irq low at t+2 (if no other source is pending).
- Write: earliest accept the cycle after AW/W valid are both seen; BVALID the cycle after accept; minimum 3 cycles per write.
- Read: ARREADY the cycle after ARVALID; RVALID the following cycle.
- Reset asserted mid-transaction aborts it: all VALID/READY low next cycle, pending lost.

## Structure
- Shared package/header (`soc_defines.vh`): register offset constants, OKAY response code, N_SRC default.
- Natural sub-module: `irq_src_cell` (one source: src_q, edge detect, pending bit, mode/clear logic), instantiated N_SRC times. The AXI-lite FSMs stay in the top level.

## Test plan
- Reset, then read all five offsets -> every read returns 0, RRESP = 0; irq = 0.
- MODE = 0x1, ENABLE = 0x1, pulse src[0] for 1 cycle -> PENDING = 0x1, irq high 2 cycles after the edge, CLAIM = 1; write CLEAR = 0x1 -> irq low 2 cycles after accept.
- Level mode, ENABLE = 0xF, hold src[2] high -> CLAIM = 3; CLEAR = 0x4 has no effect; drop src[2] -> PENDING = 0, irq falls 2 cycles later.
- Edge mode: rising edge on src[1] in the same cycle that CLEAR = 0x2 is accepted -> PENDING[1] stays 1.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable; AWREADY stays low for a second write until the first BVALID handshake completes.
- Write ENABLE with WSTRB = 4'b0000, then write to offset 0x1C -> ENABLE unchanged, both writes get BRESP = OKAY; a read of 0x1C returns 0.

Source files
------------

// File: rtl/irq_gateway_pkg.sv
// Shared definitions for the interrupt gateway: bus widths, register offsets,
// response codes, FSM state types and the claim-code helper.
package irq_gateway_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int N_SRC_DEF  = 4;

  localparam logic [AXI_ADDR_W-1:0] OFF_PENDING = 32'h00;
  localparam logic [AXI_ADDR_W-1:0] OFF_ENABLE  = 32'h04;
  localparam logic [AXI_ADDR_W-1:0] OFF_MODE    = 32'h08;
  localparam logic [AXI_ADDR_W-1:0] OFF_CLEAR   = 32'h0C;
  localparam logic [AXI_ADDR_W-1:0] OFF_CLAIM   = 32'h10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Lowest set bit index plus one; 0 when nothing is set.
  function automatic logic [AXI_DATA_W-1:0] claim_code(input logic [AXI_DATA_W-1:0] hits);
    claim_code = '0;
    for (int i = AXI_DATA_W - 1; i >= 0; i--) begin
      if (hits[i]) claim_code = AXI_DATA_W'(i + 1);
    end
  endfunction

endpackage

// File: rtl/irq_gateway_src_cell.sv
// One interrupt source: input register, rising-edge detect and the pending bit.
module irq_src_cell (
  input  logic clk,
  input  logic rstn,
  input  logic i_src,
  input  logic i_mode,
  input  logic i_clr,
  input  logic i_mode_chg,
  output logic o_pending
);

  logic r_src_q;
  logic r_pending;

  // A fresh edge beats a same-cycle clear so no interrupt is lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_src_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_src_q <= i_src;
      if (i_mode_chg)               r_pending <= 1'b0;
      else if (!i_mode)             r_pending <= i_src;
      else if (i_src && !r_src_q)   r_pending <= 1'b1;
      else if (i_clr)               r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway: per-source capture cells, enable/mode registers, a
// registered combined irq and an AXI4-lite register slave.
module irq_gateway
  import irq_gateway_pkg::*;
#(
  parameter int N_SRC    = N_SRC_DEF,
  parameter int ADDR_LEN = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_SRC-1:0]      src,
  output logic                  irq,
  input  logic [AXI_ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [AXI_DATA_W-1:0] S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [AXI_ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [AXI_DATA_W-1:0] S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY
);

  function automatic logic [N_SRC-1:0] lane_merge(input logic [N_SRC-1:0] old_v,
                                                  input logic [AXI_DATA_W-1:0] new_v,
                                                  input logic [3:0] strb);
    for (int i = 0; i < N_SRC; i++) lane_merge[i] = strb[i/8] ? new_v[i] : old_v[i];
  endfunction

  wr_state_t r_wr_state;
  rd_state_t r_rd_state;
  logic r_awready, r_bvalid, r_arready, r_rvalid, r_irq;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [N_SRC-1:0] r_enable, r_mode;
  logic [N_SRC-1:0] w_pending, w_clr, w_mode_chg, w_enable_wr, w_mode_wr;
  logic [AXI_ADDR_W-1:0] w_waddr, w_raddr;
  logic [AXI_DATA_W-1:0] w_rd_word;
  logic w_wr_fire, w_unused;

  assign w_waddr   = AXI_ADDR_W'(S_AXI_AWADDR[ADDR_LEN-1:0]);
  assign w_raddr   = AXI_ADDR_W'(S_AXI_ARADDR[ADDR_LEN-1:0]);
  assign w_wr_fire = (r_wr_state == WR_IDLE) && r_awready && S_AXI_AWVALID && S_AXI_WVALID;
  assign w_unused  = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WDATA, S_AXI_WSTRB};

  always_comb begin
    w_enable_wr = lane_merge(r_enable, S_AXI_WDATA, S_AXI_WSTRB);
    w_mode_wr   = lane_merge(r_mode, S_AXI_WDATA, S_AXI_WSTRB);
    w_clr       = '0;
    w_mode_chg  = '0;
    if (w_wr_fire && w_waddr == OFF_CLEAR) w_clr = lane_merge('0, S_AXI_WDATA, S_AXI_WSTRB);
    if (w_wr_fire && w_waddr == OFF_MODE)  w_mode_chg = w_mode_wr ^ r_mode;
  end

  for (genvar g = 0; g < N_SRC; g++) begin : g_cell
    irq_src_cell u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .i_src      (src[g]),
      .i_mode     (r_mode[g]),
      .i_clr      (w_clr[g]),
      .i_mode_chg (w_mode_chg[g]),
      .o_pending  (w_pending[g])
    );
  end

  always_comb begin
    w_rd_word = '0;
    case (w_raddr)
      OFF_PENDING: w_rd_word = AXI_DATA_W'(w_pending);
      OFF_ENABLE:  w_rd_word = AXI_DATA_W'(r_enable);
      OFF_MODE:    w_rd_word = AXI_DATA_W'(r_mode);
      OFF_CLAIM:   w_rd_word = claim_code(AXI_DATA_W'(w_pending & r_enable));
      default:     w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_irq <= 1'b0;
    else       r_irq <= |(w_pending & r_enable);
  end

  // Write channel: ready pulses the cycle after AW/W are seen together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_enable   <= '0;
      r_mode     <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            if (w_wr_fire) begin
              r_bvalid   <= 1'b1;
              r_wr_state <= WR_RESP;
              if (w_waddr == OFF_ENABLE) r_enable <= w_enable_wr;
              if (w_waddr == OFF_MODE)   r_mode   <= w_mode_wr;
            end
          end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            r_awready <= 1'b1;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read channel: data is captured on the ARREADY cycle and held until RREADY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (r_arready) begin
            r_arready <= 1'b0;
            if (S_AXI_ARVALID) begin
              r_rdata    <= w_rd_word;
              r_rvalid   <= 1'b1;
              r_rd_state <= RD_DATA;
            end
          end else if (S_AXI_ARVALID) begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  assign irq           = r_irq;
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_irq_gateway.sv
// Self-checking bench for irq_gateway: directed scenarios plus random traffic
// compared against a vector-level model of the interrupt rules.
module tb_irq_gateway;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [N-1:0] src = '0;
  logic irq;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0]  WSTRB = '0;
  logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0] BRESP, RRESP;
  logic [31:0] RDATA;

  int n_checks = 0;
  int n_err = 0;

  // Model state
  logic [N-1:0] m_pend = '0, m_en = '0, m_mode = '0, m_srcq = '0;
  logic m_irq = 1'b0;
  logic m_wr = 1'b0;
  logic [31:0] m_wa = '0, m_wd = '0;
  logic [3:0] m_ws = '0;

  irq_gateway #(.N_SRC(N), .ADDR_LEN(5)) dut (
    .clk(clk), .rstn(rstn), .src(src), .irq(irq),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, new_v, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    case (a[4:0])
      5'h00: r = 32'(m_pend);
      5'h04: r = 32'(m_en);
      5'h08: r = 32'(m_mode);
      5'h10: begin
        for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) begin r = i + 1; break; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance one clock; the model steps from the inputs present before the edge.
  task automatic tick();
    logic [N-1:0] clr_v, chg_v, new_en, new_mode, rise, nxt;
    logic [31:0] mrg;
    logic nirq;
    if (!rstn) begin
      m_pend = '0; m_en = '0; m_mode = '0; m_srcq = '0; nirq = 1'b0;
    end else begin
      clr_v = '0; chg_v = '0; new_en = m_en; new_mode = m_mode;
      if (m_wr) begin
        case (m_wa[4:0])
          5'h04: begin mrg = byte_merge(32'(m_en), m_wd, m_ws); new_en = mrg[N-1:0]; end
          5'h08: begin mrg = byte_merge(32'(m_mode), m_wd, m_ws); new_mode = mrg[N-1:0];
                       chg_v = new_mode ^ m_mode; end
          5'h0C: begin mrg = byte_merge(32'h0, m_wd, m_ws); clr_v = mrg[N-1:0]; end
          default: ;
        endcase
      end
      rise = src & ~m_srcq;
      nxt  = ((~m_mode & src) | (m_mode & (rise | (m_pend & ~clr_v)))) & ~chg_v;
      nirq = |(m_pend & m_en);
      m_pend = nxt; m_en = new_en; m_mode = new_mode; m_srcq = src;
    end
    @(posedge clk); #1;
    m_irq = nirq;
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr_start(input logic [31:0] a, d, input logic [3:0] s, input logic [N-1:0] src_acc);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    chk("awready_pulse", 32'(AWREADY), 32'd1);
    chk("wready_pulse", 32'(WREADY), 32'd1);
    src = src_acc; m_wr = 1'b1; m_wa = a; m_wd = d; m_ws = s;
    tick();
    m_wr = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    chk("awready_drop", 32'(AWREADY), 32'd0);
    chk("bvalid", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'd0);
  endtask

  task automatic wr_end(input int stall);
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("awready_blocked", 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_done", 32'(BVALID), 32'd0);
    chk("awready_after_b", 32'(AWREADY), 32'd0);
  endtask

  task automatic axi_write(input logic [31:0] a, d, input logic [3:0] s);
    wr_start(a, d, s, src);
    wr_end(0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int stall, output logic [31:0] d);
    logic [31:0] e;
    ARADDR = a; ARVALID = 1'b1;
    tick();
    chk("arready", 32'(ARREADY), 32'd1);
    e = model_read(a);
    tick();
    ARVALID = 1'b0;
    chk("rvalid", 32'(RVALID), 32'd1);
    chk("rresp", 32'(RRESP), 32'd0);
    chk("rdata", RDATA, e);
    d = RDATA;
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("rvalid_hold", 32'(RVALID), 32'd1);
      chk("rdata_hold", RDATA, e);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("rvalid_done", 32'(RVALID), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] offs [6];
    offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08;
    offs[3] = 32'h0C; offs[4] = 32'h10; offs[5] = 32'h1C;

    // Reset and idle reads
    repeat (3) tick();
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      axi_read(offs[i], 0, d);
      chk("rst_read_zero", d, 32'd0);
    end

    // Edge source 0
    axi_write(32'h08, 32'h1, 4'hF);
    axi_write(32'h04, 32'h1, 4'hF);
    src = 4'b0001; tick();
    src = 4'b0000; tick();
    chk("edge_irq_high", 32'(irq), 32'd1);
    axi_read(32'h00, 0, d); chk("edge_pending", d, 32'h1);
    axi_read(32'h10, 0, d); chk("edge_claim", d, 32'd1);
    axi_write(32'h0C, 32'h1, 4'hF);
    chk("clear_irq_low", 32'(irq), 32'd0);

    // Level source 2
    axi_write(32'h08, 32'h0, 4'hF);
    axi_write(32'h04, 32'hF, 4'hF);
    src = 4'b0100; tick(); tick();
    axi_read(32'h10, 0, d); chk("level_claim", d, 32'd3);
    axi_write(32'h0C, 32'h4, 4'hF);
    axi_read(32'h00, 0, d); chk("level_clear_ignored", d, 32'h4);
    src = 4'b0000; repeat (3) tick();
    axi_read(32'h00, 0, d); chk("level_drop", d, 32'h0);
    chk("level_irq_low", 32'(irq), 32'd0);

    // Same-cycle edge and clear on source 1
    axi_write(32'h08, 32'h2, 4'hF);
    wr_start(32'h0C, 32'h2, 4'hF, 4'b0010);
    wr_end(0);
    axi_read(32'h00, 0, d); chk("set_beats_clear", d, 32'h2);

    // Back-pressure on B and R, second write held off until B completes
    wr_start(32'h04, 32'h5, 4'hF, src);
    AWADDR = 32'h08; WDATA = 32'h0; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    wr_end(5);
    wr_start(32'h08, 32'h0, 4'hF, src);
    wr_end(0);
    axi_read(32'h04, 5, d); chk("stall_enable", d, 32'h5);

    // Null strobes and unmapped offset
    axi_write(32'h04, 32'hFFFF_FFFF, 4'h0);
    axi_read(32'h04, 0, d); chk("wstrb_zero", d, 32'h5);
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF);
    axi_read(32'h1C, 0, d); chk("unmapped_read", d, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: repeat ($urandom_range(1, 4)) begin src = N'($urandom); tick(); end
        1: begin
          wr_start(offs[$urandom_range(0, 5)], $urandom, 4'($urandom_range(0, 15)), N'($urandom));
          wr_end($urandom_range(0, 2));
        end
        default: axi_read(offs[$urandom_range(0, 5)], $urandom_range(0, 2), d);
      endcase
    end

    // Reset in the middle of a write
    src = 4'hF;
    axi_write(32'h04, 32'hF, 4'hF);
    AWADDR = 32'h04; WDATA = 32'h0; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    src = 4'h0; rstn = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("rst_mid_awready", 32'(AWREADY), 32'd0);
    chk("rst_mid_wready", 32'(WREADY), 32'd0);
    chk("rst_mid_bvalid", 32'(BVALID), 32'd0);
    rstn = 1'b1;
    tick();
    axi_read(32'h00, 0, d); chk("rst_mid_pending", d, 32'h0);
    axi_read(32'h04, 0, d); chk("rst_mid_enable", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
